// File: rtl/fg_pkg.sv
// Shared types and constants for the function-generator PWM output stage.
package fg_pkg;

   localparam int SAMPLE_W = 8;
   localparam int STEPS    = 256;
   localparam int AMP_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Attenuation is a plain logical right shift, zero-filled, no rounding.
   function automatic logic [SAMPLE_W-1:0] atten(input logic [SAMPLE_W-1:0] s,
                                                 input logic [AMP_W-1:0]    a);
      return s >> a;
   endfunction

endpackage

// File: rtl/fg_pwm_out_if.sv
// Sample-in / PWM-out bundle between the waveform selector side and fg_pwm_out.
interface fg_pwm_out_if;
   import fg_pkg::*;

   logic                en;
   logic [SAMPLE_W-1:0] sample;
   logic [AMP_W-1:0]    amp;
   logic                pwm_out;
   logic                frame_start;
   logic [SAMPLE_W-1:0] duty_q;

   modport master (
      output en, sample, amp,
      input  pwm_out, frame_start, duty_q
   );

   modport slave (
      input  en, sample, amp,
      output pwm_out, frame_start, duty_q
   );

endinterface

// File: rtl/fg_tick_gen.sv
// PWM step prescaler: counts 0..PRESCALE-1 while running and flags the last count.
module fg_tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   always_comb begin
      pre_d = pre_q;
      if (clr_i || !run_i) begin
         pre_d = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick_o = run_i && (pre_q == PRE_LAST);

endmodule

// File: rtl/fg_pwm_out.sv
// PWM output stage: latches an attenuated sample once per 256-step frame and
// drives a registered PWM bit plus a one-clock frame-boundary pulse.
//
//   state | meaning
//   IDLE  | stopped, output low, waiting for en
//   RUN   | frame in progress, reload at frame end if en still high
//   DRAIN | en dropped mid-frame, finishing current frame unchanged
module fg_pwm_out
   import fg_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int DW       = SAMPLE_W
) (
   input  logic         clk,
   input  logic         rst,
   fg_pwm_out_if.slave  bus
);

   localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [DW-1:0]   duty_q, duty_d;
   logic            pwm_q, pwm_d;
   logic            fs_q, fs_d;
   logic            tick;
   logic            running;
   logic            frame_end;
   logic            load;

   assign running   = (state_q != IDLE);
   assign frame_end = tick && (cnt_q == LAST_STEP);

   fg_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .run_i  (running),
      .clr_i  (load),
      .tick_o (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN, DRAIN: begin
            if (frame_end) begin
               if (bus.en) begin
                  load    = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               // Returning to RUN from DRAIN does not reload; that waits for frame end.
               state_d = bus.en ? RUN : DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load || (state_d == IDLE)) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + 1'b1;
      end
      duty_d = load ? atten(bus.sample, bus.amp) : duty_q;
      fs_d   = load;
      pwm_d  = running && (cnt_q < duty_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
         fs_q   <= fs_d;
      end
   end

   assign bus.pwm_out     = pwm_q;
   assign bus.frame_start = fs_q;
   assign bus.duty_q      = duty_q;

endmodule

// File: doc/fg_pwm_out.md
# fg_pwm_out

Output stage of the function generator, directly downstream of the 7-to-1 waveform selector. It consumes the selected 8-bit sample and converts it to a single-bit PWM stream for an external RC filter / DAC pin. The sample is attenuated by a programmable right shift and latched once per PWM frame, so duty changes are glitch-free. A one-clock frame-boundary pulse tells the rest of the generator when the sample was taken.

## Interface
- PRESCALE, 1: clocks per PWM step (≥1); the frame is 256 × PRESCALE clocks.
- DW, 8: sample width. Fixed at 8 for this revision.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset. Asynchronous, active-low: rst=0 forces the reset state immediately.
- en  in  1  run enable. Sampled every clock.
- sample  in  8  unsigned waveform sample from the selector output.
- amp  in  3  attenuation; effective duty = sample >> amp (0 = full scale).
- pwm_out  out  1  registered PWM output.
- frame_start  out  1  one-clock pulse in the cycle the duty register is loaded.
- duty_q  out  8  currently latched duty value, for debug/monitor.

## Operation
- States: IDLE, RUN, DRAIN.
- The prescaler `pre` counts 0..PRESCALE-1 in RUN/DRAIN. `tick` = (pre == PRESCALE-1). `pre` is held at 0 in IDLE.
- The step counter `cnt` is 8 bits. It increments on `tick` and wraps 255→0.
- Load event: duty_q <= sample >> amp, cnt <= 0, pre <= 0, frame_start <= 1.
  - sample and amp are sampled in that cycle only.
  - The shift is a logical right shift, zero-filled; there is no rounding.
- IDLE: if en=1, perform a load event and go to RUN. Otherwise stay in IDLE.
- RUN, at frame end (tick && cnt==255):
  - if en=1, perform a load event and stay in RUN;
  - if en=0, go to IDLE with cnt=0.
- RUN, when en falls before frame end: go to DRAIN. The current frame continues unchanged.
- DRAIN:
  - counts like RUN;
  - en returning to 1 sends it back to RUN, with no reload until frame end;
  - at frame end it behaves exactly as RUN does.
- pwm_out <= (state != IDLE) && (cnt < duty_q).
  - duty 0 gives a constant 0.
  - duty 255 gives 255 high steps out of 256.
- Changes on sample or amp between load events have no effect.

## Timing
- Reset values: pwm_out=0, frame_start=0, duty_q=0, cnt=0, pre=0, state=IDLE.
- frame_start is high for exactly one clock, the same cycle duty_q takes its new value. Otherwise it is 0.
- pwm_out lags (cnt, duty_q) by one clock.
  - The first high clock of a frame is the clock after frame_start.
  - That is, for duty > 0, pwm_out rises 1 clock after frame_start.
- Frame period in continuous RUN: exactly 256 × PRESCALE clocks between frame_start pulses.
- en asserted in IDLE: frame_start appears on the next rising edge.
- en deasserted mid-frame: the frame completes. pwm_out is 0 from the clock after the last step onward.
- rst asserted mid-frame: all outputs go to their reset values asynchronously. After rst deasserts, the block restarts from IDLE with no partial frame.

## Structure
- Shared package fg_pkg holds:
  - SAMPLE_W = 8;
  - STEPS = 256;
  - the state enum {IDLE, RUN, DRAIN};
  - a helper for the attenuation shift.
- One natural sub-module: fg_tick_gen, the PRESCALE counter emitting `tick`, with a clear input driven by the load event.
- The top level holds the FSM, cnt, duty_q and the pwm_out/frame_start registers.

## Test plan
- Reset check: rst=0 with en=1 and sample=0xAA gives pwm_out=0, frame_start=0, duty_q=0. After release, frame_start appears 1 clock later.
- Mid-scale: PRESCALE=1, sample=0x80, amp=0. Result: 128 high clocks per 256-clock frame, and frame_start every 256 clocks.
- Extremes and attenuation:
  - sample=0x00 gives pwm_out always 0;
  - sample=0xFF, amp=0 gives 255/256 high;
  - sample=0xFF, amp=3 gives duty_q=0x1F, i.e. 31 high clocks.
- Latching: change sample from 0x40 to 0xC0 at mid-frame. The current frame keeps 64 high clocks; the next frame has 192.
- Drain: drop en at step 100 of a frame with duty 200. The frame finishes with 200 high clocks, then pwm_out=0, with no further frame_start and state IDLE.
- Prescale and async reset: PRESCALE=4, sample=0x10.
  - Expect 64 high clocks per 1024-clock frame.
  - Pull rst low mid-high-phase: pwm_out drops without waiting for a clock edge.
